// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdm_pkg
// Description : Types, feedback levels and saturation helper shared by the
//               SDM modulator and demodulator.
// Revision    : 1.0
// ============================================================================
package sdm_pkg;

    typedef logic signed [15:0] sample_t;

    localparam sample_t SDM_FB_POS = 16'sd32767;
    localparam sample_t SDM_FB_NEG = -16'sd32767;

    // Clamp a wide signed value into the range of a signed width-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdm_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sdm_modulator_if
// Description : Valid/ready sample handshake into the SDM modulator.
// Revision    : 1.0
// ============================================================================
interface sdm_modulator_if;
    import sdm_pkg::*;

    logic    din_valid;
    sample_t din;
    logic    din_ready;

    modport master (output din_valid, output din, input  din_ready);
    modport slave  (input  din_valid, input  din, output din_ready);

endinterface
`default_nettype wire

// File: rtl/sdm_loop2.sv
`default_nettype none
// ============================================================================
// Module      : sdm_loop2
// Description : Second-order sigma-delta loop: two saturating integrators,
//               +/-32767 feedback and a sign quantizer.
// Revision    : 1.0
// ============================================================================
module sdm_loop2
    import sdm_pkg::*;
#(
    parameter int ACC1_W = 20,
    parameter int ACC2_W = 24
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    ce,
    input  wire sample_t x,
    output logic         dout
);

    localparam int SUM_W = ACC2_W + 2;

    logic signed [ACC1_W-1:0] r_a1;
    logic signed [ACC2_W-1:0] r_a2;
    logic                     r_dout;

    logic signed [SUM_W-1:0]  w_fb;
    logic signed [SUM_W-1:0]  w_sum1;
    logic signed [SUM_W-1:0]  w_sum2;
    logic signed [ACC1_W-1:0] w_a1;
    logic signed [ACC2_W-1:0] w_a2;

    // Feedback comes from the bit registered on the previous tick.
    always_comb begin
        w_fb   = r_dout ? SUM_W'(SDM_FB_POS) : SUM_W'(SDM_FB_NEG);
        w_sum1 = SUM_W'(r_a1) + SUM_W'(x) - w_fb;
        w_a1   = ACC1_W'(sat(64'(w_sum1), ACC1_W));
        w_sum2 = SUM_W'(r_a2) + SUM_W'(w_a1) - w_fb;
        w_a2   = ACC2_W'(sat(64'(w_sum2), ACC2_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a1   <= '0;
            r_a2   <= '0;
            r_dout <= 1'b0;
        end else if (ce) begin
            r_a1   <= w_a1;
            r_a2   <= w_a2;
            r_dout <= ~w_a2[ACC2_W-1];
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/sdm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : sdm_modulator
// Description : Sample handshake, one-entry queue and OSR phase control
//               around a second-order sigma-delta loop.
// Revision    : 1.0
// ============================================================================
module sdm_modulator
    import sdm_pkg::*;
#(
    parameter int OSR    = 64,
    parameter int ACC1_W = 20,
    parameter int ACC2_W = 24
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ce,
    sdm_modulator_if.slave  in_if,
    output logic            dout,
    output logic            valid_out,
    output logic            underrun
);

    localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [PH_W-1:0] r_ph;
    sample_t         r_cur;
    sample_t         r_nxt;
    logic            r_nxt_full;
    logic            r_primed;
    logic            r_underrun;
    logic            r_valid;

    logic            w_xfer;
    logic            w_boundary;

    assign in_if.din_ready = ~r_nxt_full;
    assign w_xfer          = in_if.din_valid & ~r_nxt_full;
    assign w_boundary      = ce & (r_ph == PH_W'(OSR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph       <= '0;
            r_cur      <= '0;
            r_nxt      <= '0;
            r_nxt_full <= 1'b0;
            r_primed   <= 1'b0;
            r_underrun <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= ce;
            if (ce) begin
                r_ph <= w_boundary ? '0 : r_ph + 1'b1;
            end
            if (w_xfer) begin
                r_primed <= 1'b1;
            end
            // The boundary tick itself still runs on the old sample.
            if (w_boundary) begin
                if (r_nxt_full) begin
                    r_cur      <= r_nxt;
                    r_nxt_full <= 1'b0;
                end else if (w_xfer) begin
                    r_cur <= in_if.din;
                end else if (r_primed) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_nxt      <= in_if.din;
                r_nxt_full <= 1'b1;
            end
        end
    end

    sdm_loop2 #(
        .ACC1_W (ACC1_W),
        .ACC2_W (ACC2_W)
    ) u_loop (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .x     (r_cur),
        .dout  (dout)
    );

    assign valid_out = r_valid;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: doc/sdm_modulator.md
# sdm_modulator

Second-order sigma-delta modulator: accepts signed 16-bit fixed-point audio samples over a valid/ready handshake and produces a 1-bit SDM stream, one bit per oversampling tick.

- Each sample is held for OSR ticks.
- Feedback levels are ±32767, the same binding the SDM demodulator applies on the receive side.
- Sits at the transmit end of the audio path, with its output feeding the SDM demodulator's `din` (directly in loopback tests).

## Interface
- `OSR`, 64, ticks per input sample; legal values are 2..1024.
- `ACC1_W`, 20, first integrator width in bits (signed).
- `ACC2_W`, 24, second integrator width in bits (signed).
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ce`  in  1  oversampling tick; the loop advances only in cycles where `ce`=1.
- `din_valid`  in  1  sample offered.
- `din`  in  16  signed sample (Q1.15).
- `din_ready`  out  1  block can accept a sample this cycle.
- `dout`  out  1  SDM bit.
- `valid_out`  out  1  one-cycle pulse; `dout` is new in this cycle.
- `underrun`  out  1  sticky; a sample boundary passed with no new sample queued.

## Operation
- **Storage.**
  - `cur`: the sample used by the loop.
  - `nxt`: a one-entry queue for the following sample.
  - `nxt_full`: occupancy flag for `nxt`.
  - `primed`: set when the first sample is accepted.
- **Handshake.**
  - `din_ready` = !`nxt_full`.
  - A transfer happens in any cycle where `din_valid` && `din_ready`.
  - `din` must stay stable while `din_valid`=1 and `din_ready`=0.
- **Phase counter.**
  - `ph` runs 0..OSR-1 and increments on each `ce`.
  - On a `ce` with `ph`=OSR-1, `ph` wraps to 0. This tick is the sample boundary.
- **Loop step, on every `ce`:**
  - fb = `dout` ? +32767 : −32767, using the registered `dout` from the previous tick.
  - a1' = sat_ACC1(a1 + `cur` − fb).
  - a2' = sat_ACC2(a2 + a1' − fb).
  - `dout` <= (a2' ≥ 0).
  - sat_N clamps to [−2^(N−1), 2^(N−1)−1].
  - All sums are computed at ACC2_W+2 bits before clamping.
- **Sample boundary.** `cur` switches to the new sample after the boundary tick has used the old one.
  - If `nxt_full`: `cur` <= `nxt` and `nxt_full` clears.
  - Else, if a transfer happens in the same cycle: `cur` <= `din`, bypassing the queue, and `nxt_full` stays 0.
  - Else: `cur` holds its value. If `primed`=1, `underrun` is set.
- **Transfer without a boundary.** `nxt` <= `din` and `nxt_full` sets.
- **Simultaneous dequeue and enqueue.** If a boundary dequeue and a transfer occur in the same cycle, the transfer is not possible because `din_ready` was 0 in that cycle. `nxt_full` goes to 0 and `din_ready` goes to 1 in the next cycle.
- **`underrun` clearing.** Only reset clears it.
- **No tick.** With `ce`=0, the integrators, `dout` and `ph` hold their values; the handshake still operates.
- **Before the first sample.** The loop runs with `cur`=0, producing a silence pattern.

## Timing
- **Reset values:**
  - `dout`=0, so the first fb is −32767.
  - `valid_out`=0.
  - `din_ready`=1.
  - `underrun`=0.
  - a1, a2, `cur`, `nxt`, `ph`, `nxt_full` and `primed` all 0.
- **Reset mid-operation.** All state returns to the reset values immediately (asynchronous assertion), and any queued sample is discarded. Release is synchronous to `clk`.
- **Output latency.** `dout` and `valid_out` are registered, so both update in the cycle after the `ce` cycle. `valid_out` equals `ce` delayed by one cycle.
- **Sample latency.** A sample accepted into an empty queue in cycle t enters the loop on the first tick after the next boundary.
  - The worst case is OSR ticks plus 1 cycle.
  - The bypass case applies from the next tick.
- **Back-to-back `ce`.** Supported: one bit per cycle.

## Structure
- **Package `sdm_pkg`**, shared with the demodulator:
  - typedef `sample_t` (logic signed [15:0]).
  - constants `SDM_FB_POS` = 16'sd32767 and `SDM_FB_NEG` = −16'sd32767.
  - function `sat` (value, width).
- **Sub-module `sdm_loop2`.** Contains the two integrators, the feedback and the quantizer.
  - Inputs: `ce` and `sample_t x`.
  - Output: the registered bit.
- **Top level.** The handshake, the queue, `ph` and the `underrun` logic live in `sdm_modulator`.

## Test plan
- **Silence golden sequence.** Reset, no samples, `ce`=1 every cycle.
  - First 8 bits: 1,1,0,1,0,0,1,1.
  - Ones count over 1024 bits is between 508 and 516.
  - `underrun`=0 throughout.
- **DC mapping.** Stream constant `din`=+16384 with OSR=64.
  - Ones density over 4096 bits is 0.75 ±0.01.
  - Repeating with −16384 gives 0.25 ±0.01.
- **Saturation.** Full scale +32767 for 8 samples.
  - `dout` stays 1 almost continuously: at most 2 zeros per 512 bits.
  - a1 and a2 never wrap sign; check with assertions.
- **Backpressure.** Offer samples every cycle.
  - `din_ready` goes high exactly once per OSR ticks.
  - No sample is dropped or duplicated; the checker compares the sequence of `cur` loads.
- **Underrun.** Send 2 samples, then stop.
  - `underrun` rises on the boundary after the second sample has been consumed, while `cur` keeps its last value.
  - It stays 1 until reset.
  - An `rst_n` pulse mid-stream returns all outputs to their reset values within the same cycle.
- **Loopback.** Feed `dout`/`valid_out` into the SDM demodulator (`din`/`valid_in`) with a 1 kHz sine at amplitude 16000.
  - The recovered waveform matches within ±600 LSB after filter settling.
